// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter_if : requester-side and UART-side signal bundle      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 arb_busy;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_start, tx_data, arb_busy
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_start, tx_data, arb_busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin, packet-locked sharing of one UART TX  |
// | Option macro UART_ARB_SRCID_EN: send {4'hA, owner} header per grant  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CLKS     = 16,
  parameter int BUSY_TIMEOUT = 64
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam int TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CLKS > 1) ? GAP_W'(GAP_CLKS - 1) : '0;
  localparam logic [TO_W-1:0]  TO_LAST  = (BUSY_TIMEOUT > 1) ? TO_W'(BUSY_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_owner;
  logic               r_have_owner;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_pkt_end;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_tx_start;
  logic [7:0]         r_tx_data;

  logic [7:0]         w_bytes [NUM_REQ];
  logic               w_found;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W:0]     w_sum;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_bytes[gi] = bus.req_data[8*gi +: 8];
  end

  // Scan from the highest offset down so the lowest offset at/after rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      end
      if (bus.req_valid[w_sum[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[IDX_W-1:0];
      end
    end
  end

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_have_owner <= 1'b0;
      r_rr_ptr     <= '0;
      r_pkt_end    <= 1'b0;
      r_gap_cnt    <= '0;
      r_to_cnt     <= '0;
      r_req_ready  <= '0;
      r_grant      <= '0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_req_ready <= '0;
      r_tx_start  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_have_owner) begin
            if (w_found) begin
              r_have_owner <= 1'b1;
              r_owner      <= w_sel;
              r_grant      <= onehot(w_sel);
              r_state      <= START;
`ifdef UART_ARB_SRCID_EN
              r_tx_data    <= {4'hA, 4'(w_sel)};
              r_pkt_end    <= 1'b0;
`else
              r_tx_data    <= w_bytes[w_sel];
              r_pkt_end    <= bus.req_last[w_sel];
              r_req_ready  <= onehot(w_sel);
`endif
            end
          end else if (bus.req_valid[r_owner]) begin
            r_tx_data   <= w_bytes[r_owner];
            r_pkt_end   <= bus.req_last[r_owner];
            r_req_ready <= onehot(r_owner);
            r_state     <= START;
          end
        end
        START: begin
          // A transmitter still shifting a previous byte holds off the pulse.
          if (!bus.tx_busy) begin
            r_tx_start <= 1'b1;
            r_to_cnt   <= '0;
            r_state    <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (bus.tx_busy) begin
            r_state <= WAIT_LO;
          end else if (r_to_cnt == TO_LAST) begin
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!bus.tx_busy) begin
            r_gap_cnt <= '0;
            r_state   <= GAP;
          end
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= IDLE;
            if (r_pkt_end) begin
              r_have_owner <= 1'b0;
              r_grant      <= '0;
              r_pkt_end    <= 1'b0;
              r_rr_ptr     <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.grant     = r_grant;
  assign bus.tx_start  = r_tx_start;
  assign bus.tx_data   = r_tx_data;
  assign bus.arb_busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arbiter : scoreboard bench for uart_tx_arbiter            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int GAP_CLKS     = 16;
  localparam int BUSY_TIMEOUT = 64;
  localparam int BUSY_LEN     = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .GAP_CLKS(GAP_CLKS), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [3:0] owner;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q [$];
  logic [8:0] src_mem [NUM_REQ][16];
  int         src_wr [NUM_REQ] = '{default: 0};
  int         src_rd [NUM_REQ] = '{default: 0};
  int         ready_cnt [NUM_REQ] = '{default: 0};
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  int         busy_len = BUSY_LEN;
  bit         uart_en = 1'b1;
  bit         reset_hit = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int idx, input logic [7:0] d, input logic last);
    src_mem[idx][src_wr[idx] % 16] = {last, d};
    src_wr[idx]++;
  endtask

  task automatic expect_tx(input int idx, input logic [7:0] d);
    exp_q.push_back('{owner: 4'(idx), data: d});
  endtask

  // A fresh grant is preceded by a source-id header when the option is built in.
  task automatic expect_grant(input int idx);
`ifdef UART_ARB_SRCID_EN
    expect_tx(idx, {4'hA, 4'(idx)});
`else
    if (idx < 0) $display("unused");
`endif
  endtask

  task automatic wait_ready(input int idx, input int budget, output int cyc);
    cyc = 0;
    while (bus.req_ready[idx] !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_seen", {31'd0, bus.req_ready[idx]}, 1);
  endtask

  task automatic wait_drain(input string tag);
    int  cyc;
    bit  pending;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      pending = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) if (src_rd[i] < src_wr[i]) pending = 1'b1;
    end while ((exp_q.size() != 0 || pending || bus.arb_busy !== 1'b0 || bus.grant !== '0)
                && cyc < 3000);
    check(tag, {31'd0, cyc < 3000}, 1);
  endtask

  // Requesters: present the head of each source list until it is accepted.
  initial begin
    logic [8:0] ent;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ready[i] === 1'b1) begin
          src_rd[i]++;
          ready_cnt[i]++;
        end
        if (src_rd[i] < src_wr[i]) begin
          ent = src_mem[i][src_rd[i] % 16];
          bus.req_valid[i]        = 1'b1;
          bus.req_last[i]         = ent[8];
          bus.req_data[8*i +: 8]  = ent[7:0];
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_last[i]  = 1'b0;
        end
      end
    end
  end

  // UART model and scoreboard consumer.
  initial begin
    exp_t cur;
    cur = '0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        reset_hit = 1'b0;
        check("tx_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check("tx_data", {24'd0, bus.tx_data}, {24'd0, cur.data});
          check("tx_grant", {28'd0, bus.grant}, 32'(1) << cur.owner);
        end
        if (uart_en) begin
          bus.tx_busy = 1'b1;
          repeat (busy_len) @(negedge clk);
          if (!reset_hit) check("tx_data_hold", {24'd0, bus.tx_data}, {24'd0, cur.data});
          bus.tx_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int starts;
    int snap;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_grant", {28'd0, bus.grant}, 0);
    check("rst_req_ready", {28'd0, bus.req_ready}, 0);
    check("rst_tx_start", {31'd0, bus.tx_start}, 0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 0);
    check("rst_arb_busy", {31'd0, bus.arb_busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin from rr_ptr=0: order 0,1,2,3,0
    send(0, 8'hC0, 1'b1); send(0, 8'hC4, 1'b1);
    send(1, 8'hC1, 1'b1); send(2, 8'hC2, 1'b1); send(3, 8'hC3, 1'b1);
    expect_grant(0); expect_tx(0, 8'hC0);
    expect_grant(1); expect_tx(1, 8'hC1);
    expect_grant(2); expect_tx(2, 8'hC2);
    expect_grant(3); expect_tx(3, 8'hC3);
    expect_grant(0); expect_tx(0, 8'hC4);
    wait_drain("rr_drain");

    // Single requester: latency and release timing
    send(0, 8'h55, 1'b1);
    expect_grant(0); expect_tx(0, 8'h55);
    wait_ready(0, 400, cyc);
    check("single_ready", {28'd0, bus.req_ready}, 32'h1);
    check("single_grant", {28'd0, bus.grant}, 32'h1);
    @(negedge clk);
    check("single_tx_start", {31'd0, bus.tx_start}, 1);
    cyc = 0;
    while (bus.grant !== '0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("single_release", cyc, BUSY_LEN + 1 + GAP_CLKS);
    wait_drain("single_drain");

    // Packet lock: req2 must wait for the end of req1's packet
    send(1, 8'h11, 1'b0); send(1, 8'h22, 1'b0); send(1, 8'h33, 1'b1);
    expect_grant(1); expect_tx(1, 8'h11); expect_tx(1, 8'h22); expect_tx(1, 8'h33);
    wait_ready(1, 400, cyc);
    send(2, 8'h44, 1'b1);
    expect_grant(2); expect_tx(2, 8'h44);
    wait_drain("lock_drain");

    // Busy timeout: transmitter never answers
    uart_en = 1'b0;
    send(3, 8'h5A, 1'b0); send(3, 8'hA5, 1'b1);
    expect_grant(3); expect_tx(3, 8'h5A); expect_tx(3, 8'hA5);
    cyc = 0;
    while (bus.tx_start !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("to_first_start", {31'd0, bus.tx_start}, 1);
    cyc = 0;
    starts = 0;
    while (bus.req_ready[3] !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.tx_start === 1'b1) starts++;
    end
    check("to_span", cyc, BUSY_TIMEOUT + GAP_CLKS + 1);
    check("to_single_start", starts, 0);
    wait_drain("to_drain");
    uart_en = 1'b1;

    // Reset mid-byte, then rr_ptr must restart at 0
    send(2, 8'h66, 1'b1);
    expect_grant(2); expect_tx(2, 8'h66);
    wait_drain("pre_reset_drain");
    busy_len = 30;
    send(1, 8'h99, 1'b1);
    expect_grant(1); expect_tx(1, 8'h99);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    reset_hit = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_grant", {28'd0, bus.grant}, 0);
    check("mid_rst_tx_start", {31'd0, bus.tx_start}, 0);
    check("mid_rst_req_ready", {28'd0, bus.req_ready}, 0);
    check("mid_rst_arb_busy", {31'd0, bus.arb_busy}, 0);
    rst_n = 1'b1;
    send(3, 8'h3C, 1'b1); send(2, 8'h77, 1'b1);
    expect_grant(2); expect_tx(2, 8'h77);
    expect_grant(3); expect_tx(3, 8'h3C);
    wait_drain("post_reset_drain");
    busy_len = BUSY_LEN;

    // Single byte from req2: exactly one acceptance pulse
    snap = ready_cnt[2];
    send(2, 8'h7E, 1'b1);
    expect_grant(2); expect_tx(2, 8'h7E);
    wait_drain("srcid_drain");
    check("srcid_ready_count", ready_cnt[2] - snap, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
